// File: rtl/ds_stream_packer_if.sv
// Sample stream toward the capture/DMA stage: head entry, channel tag and valid/ready handshake.
interface ds_stream_packer_if #(
    parameter int DATA_W = 16
) ();
    logic signed [DATA_W-1:0] data;
    logic [1:0]               chan;
    logic                     valid;
    logic                     ready;

    modport master (output data, output chan, output valid, input ready);
    modport slave  (input data, input chan, input valid, output ready);
endinterface

// File: rtl/ds_stream_packer.sv
// Captures the held ds2/ds4/ds8 down-sampler outputs on a phase schedule locked to the
// upstream counter, tags each with its channel and drains them through a small FIFO.
module ds_stream_packer #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int PH_DS2     = 3,
    parameter int PH_DS4     = 5,
    parameter int PH_DS8     = 9
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic signed [DATA_W-1:0]      i_ds2,
    input  logic signed [DATA_W-1:0]      i_ds4,
    input  logic signed [DATA_W-1:0]      i_ds8,
    ds_stream_packer_if.master            strm,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_W + 2;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [1:0]    PH2      = 2'(PH_DS2);
    localparam logic [2:0]    PH4      = 3'(PH_DS4);
    localparam logic [3:0]    PH8      = 4'(PH_DS8);

    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [EW-1:0] mem_q [FIFO_DEPTH];

    logic          cap2, cap4, cap8;
    logic          push_req, push_ok, pop, full, empty;
    logic [EW-1:0] push_word, head_word;

    always_comb begin
        cap2      = (cnt_q[1:0] == PH2);
        cap4      = (cnt_q[2:0] == PH4);
        cap8      = (cnt_q[3:0] == PH8);
        push_req  = cap2 | cap4 | cap8;

        push_word = {2'd2, i_ds8};
        if (cap2)      push_word = {2'd0, i_ds2};
        else if (cap4) push_word = {2'd1, i_ds4};

        full    = (level_q == FULL_LVL);
        empty   = (level_q == '0);
        pop     = !empty && strm.ready;
        // When full, a same-cycle pop frees the slot the push lands in.
        push_ok = push_req && (!full || pop);

        cnt_d    = cnt_q + 4'd1;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        ovf_d = ovf_q | (push_req && full && !pop);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && push_ok) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    // Outputs are forced to zero while empty so stale storage never leaks out.
    always_comb begin
        head_word  = mem_q[rd_ptr_q];
        strm.valid = !empty;
        strm.data  = empty ? '0 : head_word[DATA_W-1:0];
        strm.chan  = empty ? 2'd0 : head_word[EW-1:DATA_W];
    end

    assign o_level = level_q;
    assign o_ovf   = ovf_q;
endmodule

// File: tb/tb_ds_stream_packer.sv
// Self-checking bench for ds_stream_packer: reference phase counter and queue model as scoreboard.
module tb_ds_stream_packer;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] ds2 = '0, ds4 = '0, ds8 = '0;
    logic               ready = 1'b0;
    logic [3:0]         level;
    logic               ovf;

    ds_stream_packer_if #(.DATA_W(DATA_W)) sif ();
    assign sif.ready = ready;

    ds_stream_packer #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_ds2   (ds2),
        .i_ds4   (ds4),
        .i_ds8   (ds8),
        .strm    (sif.master),
        .o_level (level),
        .o_ovf   (ovf)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [17:0] exp_q[$];
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;

    logic        obs_valid, obs_ovf, exp_valid, exp_ovf, popped;
    logic [3:0]  obs_level, exp_level;
    logic [17:0] obs_word, exp_word;

    function automatic bit is_strobe(int c);
        return (c % 4 == 3) || (c % 8 == 5) || (c == 9);
    endfunction

    // One clock: sample DUT and model at the falling edge, then advance the model.
    task automatic cycle();
        logic [17:0] w;
        @(negedge clk);
        obs_valid = sif.valid;
        obs_word  = {sif.chan, sif.data};
        obs_level = level;
        obs_ovf   = ovf;
        exp_valid = (exp_q.size() != 0);
        exp_level = 4'(exp_q.size());
        exp_ovf   = m_ovf;
        exp_word  = exp_valid ? exp_q[0] : '0;
        popped    = exp_valid && ready;
        if (popped) void'(exp_q.pop_front());
        if (rst) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
        end else begin
            if (is_strobe(m_cnt)) begin
                if (m_cnt % 4 == 3)      w = {2'd0, ds2};
                else if (m_cnt % 8 == 5) w = {2'd1, ds4};
                else                     w = {2'd2, ds8};
                if (exp_q.size() < DEPTH) exp_q.push_back(w);
                else                      m_ovf = 1'b1;
            end
            m_cnt = (m_cnt + 1) % 16;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ready = 1'b0;
        cycle();
        cycle();
        n_vec++; if (obs_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b want=0", obs_valid); end
        n_vec++; if (obs_level !== 4'd0) begin n_err++; $display("FAIL reset_level got=%0d want=0", obs_level); end
        n_vec++; if (obs_ovf !== 1'b0)   begin n_err++; $display("FAIL reset_ovf got=%0b want=0", obs_ovf); end
        n_vec++; if (obs_word !== 18'd0) begin n_err++; $display("FAIL reset_head got=%h want=0", obs_word); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [17:0] got [7];
        logic [17:0] want [7];
        int seen = 0;
        want = '{18'h00011, 18'h10022, 18'h00011, 18'h20033, 18'h00011, 18'h10022, 18'h00011};
        ds2 = 16'h0011; ds4 = 16'h0022; ds8 = 16'h0033;
        ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            cycle();
            n_vec++;
            if ({obs_valid, obs_level, obs_ovf} !== {exp_valid, exp_level, exp_ovf}) begin
                n_err++;
                $display("FAIL basic_state got v=%0b l=%0d o=%0b want v=%0b l=%0d o=%0b",
                         obs_valid, obs_level, obs_ovf, exp_valid, exp_level, exp_ovf);
            end
            if (popped) begin
                n_vec++; if (obs_word !== exp_word) begin n_err++; $display("FAIL basic_head got=%h want=%h", obs_word, exp_word); end
            end
            if (obs_valid === 1'b1) begin
                if (seen < 7) got[seen] = obs_word;
                seen++;
            end
        end
        n_vec++; if (seen != 7) begin n_err++; $display("FAIL basic_pulses got=%0d want=7", seen); end
        for (int i = 0; i < 7 && i < seen; i++) begin
            n_vec++; if (got[i] !== want[i]) begin n_err++; $display("FAIL basic_seq[%0d] got=%h want=%h", i, got[i], want[i]); end
        end
    endtask

    task automatic test_overflow();
        ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ds2 = 16'h2000 + 16'(i); ds4 = 16'h4000 + 16'(i); ds8 = 16'h6000 + 16'(i);
            cycle();
            n_vec++;
            if ({obs_valid, obs_level, obs_ovf} !== {exp_valid, exp_level, exp_ovf}) begin
                n_err++;
                $display("FAIL ovf_fill_state got v=%0b l=%0d o=%0b want v=%0b l=%0d o=%0b",
                         obs_valid, obs_level, obs_ovf, exp_valid, exp_level, exp_ovf);
            end
        end
        cycle();
        n_vec++; if (obs_level !== 4'd8) begin n_err++; $display("FAIL ovf_level got=%0d want=8", obs_level); end
        n_vec++; if (obs_ovf !== 1'b1)   begin n_err++; $display("FAIL ovf_flag got=%0b want=1", obs_ovf); end
        ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            ds2 = 16'h2100 + 16'(i); ds4 = 16'h4100 + 16'(i); ds8 = 16'h6100 + 16'(i);
            cycle();
            n_vec++;
            if ({obs_valid, obs_level, obs_ovf} !== {exp_valid, exp_level, exp_ovf}) begin
                n_err++;
                $display("FAIL ovf_drain_state got v=%0b l=%0d o=%0b want v=%0b l=%0d o=%0b",
                         obs_valid, obs_level, obs_ovf, exp_valid, exp_level, exp_ovf);
            end
            if (popped) begin
                n_vec++; if (obs_word !== exp_word) begin n_err++; $display("FAIL ovf_drain_head got=%h want=%h", obs_word, exp_word); end
            end
        end
        n_vec++; if (obs_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%0b want=1", obs_ovf); end
    endtask

    task automatic test_full_pop();
        logic [17:0] oldest;
        int n;
        reset_cycle();
        ready = 1'b0;
        ds2 = 16'h0A02; ds4 = 16'h0A04; ds8 = 16'h0A08;
        n = 0;
        while (exp_q.size() < DEPTH && n < 40) begin cycle(); n++; end
        n_vec++; if (exp_q.size() < DEPTH) begin n_err++; $display("FAIL fullpop_fill timeout size=%0d want=8", exp_q.size()); end
        n = 0;
        while (!is_strobe(m_cnt) && n < 16) begin cycle(); n++; end
        oldest = exp_q[0];
        ready = 1'b1;
        cycle();
        ready = 1'b0;
        n_vec++; if (obs_word !== oldest) begin n_err++; $display("FAIL fullpop_head got=%h want=%h", obs_word, oldest); end
        n_vec++; if (obs_level !== 4'd8)  begin n_err++; $display("FAIL fullpop_level_pre got=%0d want=8", obs_level); end
        cycle();
        n_vec++; if (obs_level !== 4'd8)  begin n_err++; $display("FAIL fullpop_level got=%0d want=8", obs_level); end
        n_vec++; if (obs_ovf !== 1'b0)    begin n_err++; $display("FAIL fullpop_ovf got=%0b want=0", obs_ovf); end
        n_vec++; if (obs_word !== exp_word) begin n_err++; $display("FAIL fullpop_next_head got=%h want=%h", obs_word, exp_word); end
    endtask

    task automatic test_signed();
        logic [17:0] seen8 = '0;
        reset_cycle();
        ready = 1'b1;
        ds2 = 16'h1234; ds4 = 16'h7FFF; ds8 = 16'h8000;
        for (int i = 0; i < 17; i++) begin
            cycle();
            if (popped) begin
                n_vec++; if (obs_word !== exp_word) begin n_err++; $display("FAIL signed_head got=%h want=%h", obs_word, exp_word); end
            end
            if (obs_valid === 1'b1 && obs_word[17:16] == 2'd2) seen8 = obs_word;
        end
        n_vec++; if (seen8 !== 18'h28000) begin n_err++; $display("FAIL signed_ds8 got=%h want=28000", seen8); end
    endtask

    task automatic test_reset_mid();
        int n;
        reset_cycle();
        ready = 1'b0;
        ds2 = 16'h0C02; ds4 = 16'h0C04; ds8 = 16'h0C08;
        n = 0;
        while (exp_q.size() < 7 && n < 40) begin cycle(); n++; end
        ready = 1'b1;
        n = 0;
        while (exp_q.size() != 5 && n < 20) begin cycle(); n++; end
        n_vec++; if (exp_q.size() != 5) begin n_err++; $display("FAIL rstmid_drain timeout size=%0d want=5", exp_q.size()); end
        rst = 1'b1;
        cycle();
        n_vec++; if (obs_level !== 4'd5) begin n_err++; $display("FAIL rstmid_level_pre got=%0d want=5", obs_level); end
        rst = 1'b0;
        ready = 1'b0;
        ds2 = 16'h0D02;
        cycle();
        n_vec++; if (obs_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got=%0b want=0", obs_valid); end
        n_vec++; if (obs_level !== 4'd0) begin n_err++; $display("FAIL rstmid_level got=%0d want=0", obs_level); end
        n_vec++; if (obs_ovf !== 1'b0)   begin n_err++; $display("FAIL rstmid_ovf got=%0b want=0", obs_ovf); end
        n = 0;
        do begin cycle(); n++; end while (obs_valid !== 1'b1 && n < 10);
        n_vec++; if (n != 4) begin n_err++; $display("FAIL rstmid_first_latency got=%0d want=4", n); end
        n_vec++; if (obs_word !== 18'h00D02) begin n_err++; $display("FAIL rstmid_first_entry got=%h want=00d02", obs_word); end
    endtask

    task automatic test_random();
        reset_cycle();
        for (int i = 0; i < 1000; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            ds2 = 16'($urandom); ds4 = 16'($urandom); ds8 = 16'($urandom);
            cycle();
            n_vec++;
            if ({obs_valid, obs_level, obs_ovf} !== {exp_valid, exp_level, exp_ovf}) begin
                n_err++;
                $display("FAIL rand_state got v=%0b l=%0d o=%0b want v=%0b l=%0d o=%0b",
                         obs_valid, obs_level, obs_ovf, exp_valid, exp_level, exp_ovf);
            end
            if (popped) begin
                n_vec++; if (obs_word !== exp_word) begin n_err++; $display("FAIL rand_head got=%h want=%h", obs_word, exp_word); end
            end
        end
        n_vec++; if (obs_ovf !== 1'b0) begin n_err++; $display("FAIL rand_ovf got=%0b want=0", obs_ovf); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_signed();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
